countdown_timer: RTL and testbench
==================================

# countdown_timer

Countdown timer for the anti-theft controller, sitting between the time-parameter store and the alarm FSM. It loads a 4-bit seconds value on `start_timer` and counts it down once per second. It signals `expired` to the FSM and exports the remaining count to the display driver. It also owns the system prescaler, producing the free-running 1 Hz and 2 Hz enable pulses used by the FSM and the siren generator.

## Interface
- `CLK_FREQ`, default 100_000_000 — clock cycles per second; must be even and ≥ 4.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `value`  in  4  seconds to load; sampled only when `start_timer` is high.
- `start_timer`  in  1  one-cycle load/restart request from the FSM.
- `one_hz_enable`  out  1  one-cycle pulse every `CLK_FREQ` cycles.
- `two_hz_enable`  out  1  one-cycle pulse every `CLK_FREQ/2` cycles.
- `expired`  out  1  countdown reached zero.
- `timer_count`  out  4  remaining seconds, for display.

## Operation
- **Reset** (`reset`=0, asynchronous):
  - prescaler = 0, `timer_count` = 0, `expired` = 0, state = IDLE.
  - Both enables read 0.
- **Prescaler**
  - Counter `pc` counts 0..`CLK_FREQ/2`−1 and then wraps.
  - Phase bit `ph` toggles on each wrap.
  - `two_hz_enable` = (`pc` == `CLK_FREQ/2`−1).
  - `one_hz_enable` = `two_hz_enable` & `ph`.
  - The prescaler free-runs in every state.
- **State machine** (IDLE, RUN, DONE):
  - Any state + `start_timer`: load `timer_count` ← `value`, clear `pc` and `ph`, clear `expired`, go to RUN. If `value` == 0, go directly to DONE and set `expired`.
  - RUN + `one_hz_enable`, `timer_count` > 1: decrement.
  - RUN + `one_hz_enable`, `timer_count` == 1: `timer_count` ← 0, `expired` ← 1, go to DONE.
  - DONE: hold `timer_count` = 0 and `expired` until the next `start_timer`.
  - IDLE: `timer_count` = 0, `expired` = 0.
- **Simultaneous events**: `start_timer` in the same cycle as `one_hz_enable` means the load wins and no decrement occurs.
- **Restart mid-count**: reloads immediately and realigns the prescaler phase to the start edge.
- **Arithmetic**: `timer_count` never wraps below 0; the decrement is gated by the > 0 condition.

## Timing
- The load is visible on `timer_count` 1 cycle after the edge that samples `start_timer`.
- With start sampled at edge T0:
  - first `two_hz_enable` at T0 + `CLK_FREQ/2`;
  - first `one_hz_enable` at T0 + `CLK_FREQ`.
- With `value` = N > 0, `expired` rises and `timer_count` reaches 0 on edge T0 + N·`CLK_FREQ`.
- With `value` = 0, `expired` is high 1 cycle after the start edge.
- Enable pulses are exactly 1 cycle wide, with no gap or jitter across wraps except when realigned by `start_timer`.
- Reset assertion acts immediately. Release is synchronous to the next rising edge, with the prescaler starting from 0.

## Configuration
- Macro `TIMER_EXPIRED_PULSE_EN`.
- Defined: `expired` is a 1-cycle pulse on entry to DONE, then returns to 0 while the state stays DONE. With `value` = 0 the pulse occurs 1 cycle after start.
- Undefined (default): `expired` is a level, held from entry to DONE until the next `start_timer` or reset.

## Test plan
- `CLK_FREQ`=8, start with `value`=3 at T0 → `timer_count` sequence 3, 2, 1, 0 at T0+1, T0+8, T0+16, T0+24; `expired`=1 from T0+24.
- Start with `value`=0 → `expired`=1 and `timer_count`=0 one cycle after start; no `one_hz_enable` is needed.
- `value`=9 running, restart with `value`=4 after 2 s → `timer_count`=4, `expired`=0, next `one_hz_enable` exactly 8 cycles after the restart edge.
- `start_timer` coincident with `one_hz_enable` during RUN at count 5, `value`=7 → `timer_count`=7, no decrement.
- `reset` pulled low mid-count at `timer_count`=6 → all outputs 0 asynchronously; after release, enables resume with `two_hz_enable` first at +4 cycles.
- Free-running check over 64 cycles in IDLE → `two_hz_enable` every 4 cycles, `one_hz_enable` every 8; with `TIMER_EXPIRED_PULSE_EN` defined, case 1 shows `expired` high only at T0+24.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Groups the load request and the timer outputs exchanged with the alarm FSM and display driver.
// Purely combinational bundle; no storage.
// No backpressure: start_timer is a one-cycle request, outputs are continuously valid.
//
// Signals:
//   value          seconds to load (sampled with start_timer)
//   start_timer    one-cycle load/restart request
//   one_hz_enable  one-cycle pulse every CLK_FREQ cycles
//   two_hz_enable  one-cycle pulse every CLK_FREQ/2 cycles
//   expired        countdown reached zero
//   timer_count    remaining seconds
interface countdown_timer_if;
    logic [3:0] value;
    logic       start_timer;
    logic       one_hz_enable;
    logic       two_hz_enable;
    logic       expired;
    logic [3:0] timer_count;

    // Requester side (alarm FSM / test driver)
    modport master (
        output value,
        output start_timer,
        input  one_hz_enable,
        input  two_hz_enable,
        input  expired,
        input  timer_count
    );

    // Timer side
    modport slave (
        input  value,
        input  start_timer,
        output one_hz_enable,
        output two_hz_enable,
        output expired,
        output timer_count
    );
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown timer with free-running 1 Hz / 2 Hz prescaler for the anti-theft controller.
// Latency: load visible 1 cycle after start_timer; count steps on each sampled one_hz_enable.
// No backpressure: start_timer always accepted and overrides any in-flight count or tick.
//
// Ports:
//   clock   system clock, rising edge
//   reset   asynchronous active-low reset
//   tif     countdown_timer_if.slave (value, start_timer in; enables, expired, timer_count out)
//
// Build option: define TIMER_EXPIRED_PULSE_EN to make expired a one-cycle pulse on entry
// to DONE; otherwise expired is a level held until the next start_timer or reset.
module countdown_timer #(
    parameter int CLK_FREQ = 100_000_000   // cycles per second, even and >= 4
) (
    input  logic              clock,
    input  logic              reset,
    countdown_timer_if.slave  tif
);

    localparam int HALF = CLK_FREQ / 2;
    localparam int PCW  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PCW-1:0] PC_MAX = PCW'(HALF - 1);
    localparam logic [PCW-1:0] PC_ONE = PCW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic           ph_q, ph_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           exp_q, exp_d;

    logic           pc_wrap;
    logic           two_hz;
    logic           one_hz;

    // Enables are decoded from registered prescaler state, so they read 0 in reset
    // (pc = 0 never equals HALF-1 because HALF >= 2).
    assign pc_wrap = (pc_q == PC_MAX);
    assign two_hz  = pc_wrap;
    assign one_hz  = pc_wrap & ph_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ph_q    <= 1'b0;
            cnt_q   <= 4'd0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;

        // Free-running prescaler; ph marks the second half of each second.
        if (pc_wrap) begin
            pc_d = '0;
            ph_d = ~ph_q;
        end else begin
            pc_d = pc_q + PC_ONE;
            ph_d = ph_q;
        end

        if (tif.start_timer) begin
            // Load wins over a coincident tick; prescaler realigns to this edge so the
            // first full second is counted from the restart.
            pc_d  = '0;
            ph_d  = 1'b0;
            cnt_d = tif.value;
            if (tif.value == 4'd0) begin
                exp_d   = 1'b1;
                state_d = DONE;
            end else begin
                exp_d   = 1'b0;
                state_d = RUN;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = 4'd0;
                    exp_d = 1'b0;
                end
                RUN: begin
                    if (one_hz) begin
                        if (cnt_q > 4'd1) begin
                            cnt_d = cnt_q - 4'd1;
                        end else begin
                            // Last second (or defensive zero): never wraps below 0.
                            cnt_d   = 4'd0;
                            exp_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    cnt_d = 4'd0;
`ifdef TIMER_EXPIRED_PULSE_EN
                    exp_d = 1'b0;
`else
                    exp_d = exp_q;
`endif
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    exp_d   = 1'b0;
                end
            endcase
        end
    end

    assign tif.one_hz_enable = one_hz;
    assign tif.two_hz_enable = two_hz;
    assign tif.expired       = exp_q;
    assign tif.timer_count   = cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with CLK_FREQ = 8 (2 Hz tick every 4 cycles, 1 Hz every 8).
// Inputs change 1 time unit after the rising edge; outputs are observed at the same point.
// Expired expectations follow the TIMER_EXPIRED_PULSE_EN build option.
module tb_countdown_timer;

    localparam int CF = 8;

`ifdef TIMER_EXPIRED_PULSE_EN
    localparam logic EXP_HOLD = 1'b0;
`else
    localparam logic EXP_HOLD = 1'b1;
`endif

    logic clock;
    logic reset;

    countdown_timer_if tif ();

    countdown_timer #(.CLK_FREQ(CF)) dut (
        .clock (clock),
        .reset (reset),
        .tif   (tif.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges, landing 1 unit after the last one.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Pulse start_timer so that the next edge (T0) samples it; returns just after T0.
    task automatic start(input logic [3:0] v);
        tif.value       = v;
        tif.start_timer = 1'b1;
        step(1);
        tif.start_timer = 1'b0;
    endtask

    int two_cnt, one_cnt, first_two, first_one, last_two, gap_err, idle_err;

    initial begin
        tif.value       = 4'd0;
        tif.start_timer = 1'b0;
        reset           = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_count", tif.timer_count, 0);
        check("rst_expired", tif.expired, 0);
        check("rst_two_hz", tif.two_hz_enable, 0);
        check("rst_one_hz", tif.one_hz_enable, 0);

        // Release between edges; first edge after release starts the prescaler from 0
        step(2);
        reset = 1'b1;

        // Free-running prescaler in IDLE over 64 edges
        two_cnt = 0; one_cnt = 0; first_two = -1; first_one = -1;
        last_two = -1; gap_err = 0; idle_err = 0;
        for (int i = 1; i <= 64; i++) begin
            step(1);
            if (tif.two_hz_enable) begin
                two_cnt++;
                if (first_two < 0) first_two = i;
                if (last_two >= 0 && (i - last_two) != 4) gap_err++;
                last_two = i;
            end
            if (tif.one_hz_enable) begin
                one_cnt++;
                if (first_one < 0) first_one = i;
                if (!tif.two_hz_enable) gap_err++;
            end
            if (tif.timer_count != 4'd0 || tif.expired) idle_err++;
        end
        check("idle_two_hz_count", two_cnt, 16);
        check("idle_one_hz_count", one_cnt, 8);
        check("idle_first_two_hz", first_two, 3);
        check("idle_first_one_hz", first_one, 7);
        check("idle_pulse_spacing", gap_err, 0);
        check("idle_outputs_zero", idle_err, 0);

        // Case 1: value 3 -> 3,2,1,0 at T0+1, T0+8, T0+16, T0+24
        start(4'd3);                                   // now after T0
        check("c1_load", tif.timer_count, 3);
        check("c1_exp_after_load", tif.expired, 0);
        step(3);                                       // T0+3
        check("c1_first_two_hz", tif.two_hz_enable, 1);
        check("c1_no_one_hz_at_half", tif.one_hz_enable, 0);
        step(4);                                       // T0+7
        check("c1_first_one_hz", tif.one_hz_enable, 1);
        check("c1_hold_before_tick", tif.timer_count, 3);
        step(1);                                       // T0+8
        check("c1_count_t8", tif.timer_count, 2);
        check("c1_one_hz_one_wide", tif.one_hz_enable, 0);
        step(8);                                       // T0+16
        check("c1_count_t16", tif.timer_count, 1);
        step(7);                                       // T0+23
        check("c1_exp_before_t24", tif.expired, 0);
        step(1);                                       // T0+24
        check("c1_count_t24", tif.timer_count, 0);
        check("c1_exp_t24", tif.expired, 1);
        step(1);                                       // T0+25
        check("c1_exp_t25", tif.expired, EXP_HOLD);
        step(10);
        check("c1_done_count", tif.timer_count, 0);
        check("c1_done_exp", tif.expired, EXP_HOLD);

        // Case 2: value 0 expires one cycle after start without any tick
        start(4'd0);
        check("c2_count", tif.timer_count, 0);
        check("c2_exp", tif.expired, 1);
        step(1);
        check("c2_exp_next", tif.expired, EXP_HOLD);

        // Boundary: value 1 expires on the first 1 Hz tick
        start(4'd1);
        check("c1b_load", tif.timer_count, 1);
        check("c1b_exp_clear", tif.expired, 0);
        step(8);
        check("c1b_count_t8", tif.timer_count, 0);
        check("c1b_exp_t8", tif.expired, 1);

        // Boundary: maximum load
        start(4'd15);
        check("c15_load", tif.timer_count, 15);

        // Case 3: value 9, restart with 4 after 2 s
        start(4'd9);
        check("c3_load", tif.timer_count, 9);
        step(16);
        check("c3_after_2s", tif.timer_count, 7);
        start(4'd4);                                   // T1
        check("c3_reload", tif.timer_count, 4);
        check("c3_exp", tif.expired, 0);
        step(3);                                       // T1+3
        check("c3_two_hz_realigned", tif.two_hz_enable, 1);
        step(3);                                       // T1+6
        check("c3_no_early_one_hz", tif.one_hz_enable, 0);
        step(1);                                       // T1+7
        check("c3_one_hz_t8", tif.one_hz_enable, 1);
        step(1);                                       // T1+8
        check("c3_dec", tif.timer_count, 3);

        // Case 4: start coincident with one_hz at count 5
        start(4'd5);
        step(7);                                       // one_hz high now
        check("c4_tick_present", tif.one_hz_enable, 1);
        check("c4_count_before", tif.timer_count, 5);
        start(4'd7);
        check("c4_load_wins", tif.timer_count, 7);
        check("c4_exp", tif.expired, 0);
        step(7);
        check("c4_next_tick", tif.one_hz_enable, 1);
        check("c4_still_7", tif.timer_count, 7);
        step(1);
        check("c4_dec", tif.timer_count, 6);

        // Case 5: asynchronous reset mid-count at 6
        #2;
        reset = 1'b0;
        #1;
        check("c5_async_count", tif.timer_count, 0);
        check("c5_async_exp", tif.expired, 0);
        check("c5_async_two_hz", tif.two_hz_enable, 0);
        check("c5_async_one_hz", tif.one_hz_enable, 0);
        step(2);
        check("c5_held_count", tif.timer_count, 0);
        reset = 1'b1;
        step(2);
        check("c5_no_early_two_hz", tif.two_hz_enable, 0);
        step(1);
        check("c5_two_hz_resume", tif.two_hz_enable, 1);
        check("c5_idle_count", tif.timer_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
